char_glyph_ctrl: RTL and testbench
==================================

Name: char_glyph_ctrl

Overview:
Sequencer and arbiter in front of the 36-glyph character bitmap array (4x3 pixel glyphs, one output bit per glyph, shared x/y/write/data_in bus).
It shares that single address bus between two requesters:
- the VGA renderer, which does per-pixel glyph lookups;
- the host (Arduino) loader, which streams a 12-bit pattern into the array.

It serialises each pattern into 12 single-bit write cycles, gated by video blanking, and muxes the addressed glyph bit back to the renderer.

Parameters:
NUM_CHARS, 36, number of glyph instances / width of mem_rdata
GLYPH_W, 4, pixels per glyph row (mem_x range 0..GLYPH_W-1)
GLYPH_H, 3, rows per glyph (mem_y range 0..GLYPH_H-1)

Ports:
clock  in  1  system clock
rst  in  1  asynchronous active-high reset
blank  in  1  video blanking; host writes may only issue while high
rd_req  in  1  renderer lookup request (single cycle, any cycle)
rd_char  in  6  glyph index 0..35
rd_x  in  2  pixel column
rd_y  in  3  pixel row
rd_pixel  out  1  looked-up pixel
rd_valid  out  1  rd_pixel valid strobe
ld_valid  in  1  host pattern offer
ld_ready  out  1  controller accepts pattern (idle)
ld_pattern  in  12  pattern; bit index = y*GLYPH_W + x
ld_busy  out  1  load in progress
ld_done  out  1  one-cycle pulse after final write
mem_write  out  1  to array write
mem_x  out  2  to array x
mem_y  out  3  to array y
mem_data  out  1  to array data_in
mem_rdata  in  36  from array data_out (combinational read of x/y)

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, pattern shift register and counters cleared.
  - ld_ready rises the first cycle after rst deasserts.
  - The array's rst_n is driven from ~rst at top level.
- FSM states:
  - IDLE: ld_ready=1. ld_valid&&ld_ready captures ld_pattern and clears the index to 0 -> LOAD.
  - LOAD: ld_busy=1. A write slot occurs on a cycle with blank=1 and rd_req=0. In a write slot:
    - mem_write=1 next cycle, with mem_x=idx%4, mem_y=idx/4, mem_data=pattern[idx];
    - idx increments.
    - After idx 11 is issued -> DONE.
  - DONE: ld_done=1 for one cycle, then -> IDLE.
- Write order is x fastest, then y: (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2).
- Read path, 2-cycle latency:
  - Cycle 0: rd_req sampled.
  - Cycle 1: mem_x/mem_y registered from rd_x/rd_y, mem_write=0.
  - Cycle 2: rd_pixel = mem_rdata[rd_char (pipelined)], rd_valid=1.
  - Back-to-back requests are fully pipelined: one result per cycle.
- Out-of-range reads return rd_pixel=0 with rd_valid still 1:
  - rd_char >= NUM_CHARS;
  - rd_y >= GLYPH_H.
- Arbitration: renderer always has priority. A cycle with rd_req=1 or blank=0 is a stall slot.
  - In a stall slot the load holds idx and mem_write=0.
  - The load resumes on the next write slot.
  - No write ever coincides with a read address cycle.
- mem_write is never asserted outside LOAD. mem_x/mem_y hold their last value when the bus is unused.
- ld_valid while busy is ignored (ld_ready=0). The pattern is not re-sampled mid-load.
- Reset mid-load: aborts immediately.
  - No ld_done pulse.
  - Array contents revert to reset glyphs via the array's own reset.
  - Pending rd_valid pipeline stages are flushed.
- Simultaneous ld_valid accept and rd_req in IDLE: the pattern is captured and the read is serviced. The first write slot is no earlier than the next cycle.

Decomposition:
- Shared package holds:
  - NUM_CHARS, GLYPH_W, GLYPH_H;
  - PATTERN_W = GLYPH_W*GLYPH_H;
  - the FSM state enum (IDLE, LOAD, DONE);
  - function pat_index(x, y) = y*GLYPH_W + x.
- One natural sub-module: glyph_rd_pipe, the 2-stage read address/select pipeline with range checks. The FSM/arbiter stays in the top.

Test Plan:
1. Reset, then rd_req with rd_char=0 (A), rd_x=0, rd_y=0 and mem_rdata[0]=1 -> rd_valid=1 and rd_pixel=1 exactly 2 cycles later; all outputs 0 during rst.
2. blank=1 held, ld_pattern=12'hA5C accepted -> 12 consecutive mem_write pulses in order (0,0)..(3,2) with mem_data=pattern[y*4+x]; ld_done pulses on cycle 14 after accept; ld_ready returns to 1 the following cycle.
3. During a load, toggle blank low for 5 cycles mid-stream (after idx 4) -> no mem_write during those cycles, idx resumes at 5, total writes still exactly 12.
4. blank=1 load with rd_req asserted every other cycle -> reads return with 2-cycle latency, correct pixels, no write on read-address cycles; load completes in 24 cycles.
5. rd_char=40 or rd_y=5 -> rd_valid=1, rd_pixel=0 regardless of mem_rdata=all-ones.
6. Assert rst at write idx 7 -> mem_write drops immediately, no ld_done, rd_valid=0 for 2 cycles after release, ld_ready=1 after deassert.

Source files
------------

// File: rtl/char_glyph_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the glyph
// array controller: geometry of a glyph and pattern bit order.
package char_glyph_ctrl_pkg;

  localparam int NUM_CHARS = 36;
  localparam int GLYPH_W   = 4;
  localparam int GLYPH_H   = 3;
  localparam int PATTERN_W = GLYPH_W * GLYPH_H;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } ld_state_t;

  // Bit position of pixel (x, y) inside a host pattern.
  function automatic logic [3:0] pat_index(
    input logic [1:0] x,
    input logic [2:0] y
  );
    return 4'(int'(y) * GLYPH_W + int'(x));
  endfunction

endpackage

// File: rtl/glyph_rd_pipe.sv
// Two-stage renderer lookup: stage 1 rides the address cycle,
// stage 2 selects the addressed glyph bit from the array output.
module glyph_rd_pipe
  import char_glyph_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 req,
  input  logic [5:0]           char_idx,
  input  logic [2:0]           row,
  input  logic [NUM_CHARS-1:0] rdata,
  output logic                 pixel,
  output logic                 valid
);

  logic       s1_valid;
  logic       s1_ok;
  logic [5:0] s1_char;
  logic       in_range;

  assign in_range = (char_idx < 6'(NUM_CHARS))
                 && (row < 3'(GLYPH_H));

  // Stage 1: hold the glyph index while the array decodes x/y.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ok    <= 1'b0;
      s1_char  <= '0;
    end else begin
      s1_valid <= req;
      s1_ok    <= req && in_range;
      s1_char  <= char_idx;
    end
  end

  // Stage 2: pick the glyph bit; out-of-range lookups read as 0.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pixel <= 1'b0;
      valid <= 1'b0;
    end else begin
      pixel <= s1_ok && rdata[s1_char];
      valid <= s1_valid;
    end
  end

endmodule

// File: rtl/char_glyph_ctrl.sv
// Arbiter/sequencer sharing the glyph array bus between renderer
// lookups (priority) and host pattern loads during blanking.
module char_glyph_ctrl
  import char_glyph_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 blank,
  input  logic                 rd_req,
  input  logic [5:0]           rd_char,
  input  logic [1:0]           rd_x,
  input  logic [2:0]           rd_y,
  output logic                 rd_pixel,
  output logic                 rd_valid,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [11:0]          ld_pattern,
  output logic                 ld_busy,
  output logic                 ld_done,
  output logic                 mem_write,
  output logic [1:0]           mem_x,
  output logic [2:0]           mem_y,
  output logic                 mem_data,
  input  logic [NUM_CHARS-1:0] mem_rdata
);

  ld_state_t state;
  ld_state_t state_nx;

  logic [PATTERN_W-1:0] pattern;
  logic [1:0]           wx;
  logic [1:0]           wy;
  logic                 accept;
  logic                 slot;
  logic                 last;

  assign ld_busy = (state == LOAD);

  // Load FSM state register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, handshake accept and write-slot decode.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    slot     = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        accept = ld_valid && ld_ready;
        if (accept) state_nx = LOAD;
      end
      LOAD: begin
        slot = blank && !rd_req;
        last = slot
            && (wx == 2'(GLYPH_W - 1))
            && (wy == 2'(GLYPH_H - 1));
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pattern capture and x-fastest write cursor.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pattern <= '0;
      wx      <= '0;
      wy      <= '0;
    end else if (accept) begin
      pattern <= ld_pattern;
      wx      <= '0;
      wy      <= '0;
    end else if (slot) begin
      if (wx == 2'(GLYPH_W - 1)) begin
        wx <= '0;
        wy <= wy + 2'd1;
      end else begin
        wx <= wx + 2'd1;
      end
    end
  end

  // Array bus: read address wins, else a pending write, else hold.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mem_write <= 1'b0;
      mem_x     <= '0;
      mem_y     <= '0;
      mem_data  <= 1'b0;
    end else begin
      mem_write <= slot;
      if (rd_req) begin
        mem_x <= rd_x;
        mem_y <= rd_y;
      end else if (slot) begin
        mem_x    <= wx;
        mem_y    <= {1'b0, wy};
        mem_data <= pattern[pat_index(wx, {1'b0, wy})];
      end
    end
  end

  // Host status: ready only while idle and not just accepting.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
    end else begin
      ld_ready <= (state == IDLE) && !accept;
      ld_done  <= (state == DONE);
    end
  end

  glyph_rd_pipe u_rd_pipe (
    .clock    (clock),
    .rst      (rst),
    .req      (rd_req),
    .char_idx (rd_char),
    .row      (rd_y),
    .rdata    (mem_rdata),
    .pixel    (rd_pixel),
    .valid    (rd_valid)
  );

endmodule

// File: tb/tb_char_glyph_ctrl.sv
// Bench for char_glyph_ctrl: behavioural model plus directed
// scenarios covering reads, loads, stalls, range and reset.
module tb_char_glyph_ctrl;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        blank = 1'b0;
  logic        rd_req = 1'b0;
  logic [5:0]  rd_char = '0;
  logic [1:0]  rd_x = '0;
  logic [2:0]  rd_y = '0;
  logic        ld_valid = 1'b0;
  logic [11:0] ld_pattern = '0;
  logic        ones = 1'b0;
  logic [35:0] mem_rdata;
  logic        rd_pixel, rd_valid, ld_ready, ld_busy, ld_done;
  logic        mem_write, mem_data;
  logic [1:0]  mem_x;
  logic [2:0]  mem_y;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  char_glyph_ctrl dut (
    .clock      (clock),
    .rst        (rst),
    .blank      (blank),
    .rd_req     (rd_req),
    .rd_char    (rd_char),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_pixel   (rd_pixel),
    .rd_valid   (rd_valid),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_pattern (ld_pattern),
    .ld_busy    (ld_busy),
    .ld_done    (ld_done),
    .mem_write  (mem_write),
    .mem_x      (mem_x),
    .mem_y      (mem_y),
    .mem_data   (mem_data),
    .mem_rdata  (mem_rdata)
  );

  // Stand-in array output: a distinct 36-bit word per (x, y).
  function automatic logic [35:0] rdata_fn(
    input logic [1:0] x,
    input logic [2:0] y
  );
    logic [35:0] b;
    int s;
    b = 36'h9_6C3A_5E1D;
    s = ((int'(y) * 4 + int'(x)) * 5) % 36;
    return (b << s) | (b >> (36 - s));
  endfunction

  assign mem_rdata = ones ? '1 : rdata_fn(mem_x, mem_y);

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  // Behavioural model: expected outputs for the coming cycle.
  logic e_rd_valid = 0, e_rd_pixel = 0, e_mem_write = 0;
  logic e_mem_data = 0, e_ready = 0, e_busy = 0, e_done = 0;
  logic [1:0] e_mem_x = 0;
  logic [2:0] e_mem_y = 0;
  logic p_v = 0, p_pix = 0;
  logic m_loading = 0, m_fin = 0;
  int m_idx = 0;
  logic [11:0] m_pat = 0;

  always @(posedge clock or posedge rst) begin
    logic acc, slot, fin, ok;
    logic [35:0] rv;
    if (rst) begin
      e_rd_valid <= 0; e_rd_pixel <= 0; e_mem_write <= 0;
      e_mem_data <= 0; e_ready <= 0; e_busy <= 0; e_done <= 0;
      e_mem_x <= 0; e_mem_y <= 0; p_v <= 0; p_pix <= 0;
      m_loading <= 0; m_fin <= 0; m_idx <= 0; m_pat <= 0;
    end else begin
      acc  = ld_valid && e_ready;
      slot = m_loading && blank && !rd_req;
      fin  = slot && (m_idx == 11);
      rv   = ones ? '1 : rdata_fn(rd_x, rd_y);
      ok   = (rd_char < 36) && (rd_y < 3);
      e_rd_valid <= p_v;
      e_rd_pixel <= p_pix;
      p_v   <= rd_req;
      p_pix <= rd_req && ok && rv[rd_char];
      e_mem_write <= slot;
      if (rd_req) begin
        e_mem_x <= rd_x;
        e_mem_y <= rd_y;
      end else if (slot) begin
        e_mem_x    <= 2'(m_idx % 4);
        e_mem_y    <= 3'(m_idx / 4);
        e_mem_data <= m_pat[m_idx];
      end
      e_done  <= m_fin;
      e_ready <= !m_loading && !m_fin && !acc;
      e_busy  <= acc || (m_loading && !fin);
      if (acc) begin
        m_loading <= 1;
        m_idx <= 0;
        m_pat <= ld_pattern;
      end else if (slot) begin
        m_idx <= m_idx + 1;
        if (fin) m_loading <= 0;
      end
      m_fin <= fin;
    end
  end

  // Compare every cycle against the model.
  always @(negedge clock) begin
    chk("rd_valid", int'(rd_valid), int'(e_rd_valid));
    chk("rd_pixel", int'(rd_pixel), int'(e_rd_pixel));
    chk("mem_write", int'(mem_write), int'(e_mem_write));
    chk("mem_x", int'(mem_x), int'(e_mem_x));
    chk("mem_y", int'(mem_y), int'(e_mem_y));
    if (e_mem_write)
      chk("mem_data", int'(mem_data), int'(e_mem_data));
    chk("ld_ready", int'(ld_ready), int'(e_ready));
    chk("ld_busy", int'(ld_busy), int'(e_busy));
    chk("ld_done", int'(ld_done), int'(e_done));
  end

  // Observe writes and done pulses for the directed checks.
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [11:0] got = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mem_write) begin
      wr_cnt <= wr_cnt + 1;
      got[int'(mem_y) * 4 + int'(mem_x)] <= mem_data;
    end
    if (ld_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_done(input int d0, input int lim,
                           input string n);
    int k;
    k = 0;
    while (done_cnt == d0 && k < lim) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk({n, "_done_seen"}, int'(done_cnt > d0), 1);
  endtask

  task automatic wait_writes(input int w0, input int n,
                             input int lim, input string nm);
    int k;
    k = 0;
    while (wr_cnt - w0 < n && k < lim) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk({nm, "_writes_seen"}, int'(wr_cnt - w0 >= n), 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int c0, w0, w1, d0, k;

    // 1: reset state, then one lookup with 2-cycle latency.
    repeat (2) @(negedge clock);
    #1;
    chk("t1_rst_ready", int'(ld_ready), 0);
    chk("t1_rst_valid", int'(rd_valid), 0);
    @(posedge clock);
    #2 rst = 1'b0;
    @(posedge clock);
    @(negedge clock);
    #1 chk("t1_ready_rise", int'(ld_ready), 1);
    step();
    rd_req = 1; rd_char = 0; rd_x = 0; rd_y = 0;
    step();
    rd_req = 0;
    step();
    @(negedge clock);
    #1;
    chk("t1_valid", int'(rd_valid), 1);
    chk("t1_pixel", int'(rd_pixel), 1);

    // 2: uninterrupted load of A5C.
    step();
    blank = 1; ld_pattern = 12'hA5C; ld_valid = 1;
    c0 = cyc; w0 = wr_cnt; d0 = done_cnt;
    step();
    ld_valid = 0;
    wait_done(d0, 40, "t2");
    chk("t2_done_cycle", done_cyc - c0, 14);
    chk("t2_writes", wr_cnt - w0, 12);
    chk("t2_pattern", int'(got), 'hA5C);
    @(negedge clock);
    #1 chk("t2_ready_back", int'(ld_ready), 1);

    // 3: blanking drops for 5 cycles after idx 4.
    step();
    ld_pattern = 12'h3C9; ld_valid = 1;
    w0 = wr_cnt; d0 = done_cnt;
    step();
    ld_valid = 0;
    wait_writes(w0, 5, 30, "t3");
    blank = 0;
    w1 = wr_cnt;
    repeat (5) @(negedge clock);
    #1;
    chk("t3_stalled", wr_cnt - w1, 0);
    chk("t3_busy", int'(ld_busy), 1);
    blank = 1;
    wait_done(d0, 40, "t3");
    chk("t3_writes", wr_cnt - w0, 12);
    chk("t3_pattern", int'(got), 'h3C9);
    repeat (3) step();

    // 4: renderer requests every other cycle during a load.
    ld_pattern = 12'h5A3; ld_valid = 1; rd_req = 0;
    c0 = cyc; w0 = wr_cnt; d0 = done_cnt;
    step();
    ld_valid = 0;
    k = 1;
    while (done_cnt == d0 && k < 60) begin
      rd_req  = k[0];
      rd_char = 6'(k % 36);
      rd_x    = 2'(k);
      rd_y    = 3'(k % 3);
      step();
      k++;
    end
    rd_req = 0;
    chk("t4_done_seen", int'(done_cnt > d0), 1);
    chk("t4_done_cycle", done_cyc - c0, 26);
    chk("t4_writes", wr_cnt - w0, 12);
    chk("t4_pattern", int'(got), 'h5A3);
    repeat (3) step();

    // 5: out-of-range lookups against an all-ones array.
    ones = 1;
    rd_req = 1; rd_char = 40; rd_x = 1; rd_y = 0;
    step();
    rd_char = 5; rd_x = 2; rd_y = 5;
    step();
    rd_char = 35; rd_x = 3; rd_y = 2;
    @(negedge clock);
    #1;
    chk("t5_c40_valid", int'(rd_valid), 1);
    chk("t5_c40_pixel", int'(rd_pixel), 0);
    step();
    rd_char = 36; rd_x = 0; rd_y = 0;
    @(negedge clock);
    #1;
    chk("t5_y5_valid", int'(rd_valid), 1);
    chk("t5_y5_pixel", int'(rd_pixel), 0);
    step();
    rd_req = 0;
    @(negedge clock);
    #1 chk("t5_c35_pixel", int'(rd_pixel), 1);
    step();
    @(negedge clock);
    #1;
    chk("t5_c36_valid", int'(rd_valid), 1);
    chk("t5_c36_pixel", int'(rd_pixel), 0);
    step();
    ones = 0;
    repeat (2) step();

    // 6: reset while write idx 7 is on the bus.
    ld_pattern = 12'hFFF; ld_valid = 1;
    w0 = wr_cnt; d0 = done_cnt;
    step();
    ld_valid = 0;
    k = 1;
    while (k < 60) begin
      rd_req = k[0];
      rd_char = 6'(k % 36);
      @(negedge clock);
      #1;
      if (wr_cnt - w0 >= 8) break;
      @(posedge clock);
      #2 k++;
    end
    chk("t6_idx7_seen", wr_cnt - w0, 8);
    rst = 1;
    rd_req = 0;
    #1;
    chk("t6_write_drop", int'(mem_write), 0);
    chk("t6_busy_drop", int'(ld_busy), 0);
    repeat (2) @(posedge clock);
    #2 rst = 0;
    @(negedge clock);
    #1 chk("t6_flush1", int'(rd_valid), 0);
    @(negedge clock);
    #1;
    chk("t6_flush2", int'(rd_valid), 0);
    chk("t6_ready", int'(ld_ready), 1);
    repeat (20) @(negedge clock);
    #1 chk("t6_no_done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
